// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side UART sequencer.
// Sends start, 8 data bits LSB first, an optional parity bit and a stop bit.
// Each bit is timed by an internal baud counter. The parity value comes from
// an external registered parity generator, which is driven through
// parity_load/parity_data and answers on parity_in.
// Every output is registered. Each output register is loaded with the value
// that belongs to the state being entered on that clock edge.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       parity_load,
    output logic [7:0] parity_data,
    input  logic       parity_in,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic PAR_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       parity_data_nxt;
    logic             parity_load_nxt;
    logic             tx_out_nxt;
    logic             tx_busy_nxt;
    logic             tx_done_nxt;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);

    // State, counters and all registered outputs. Reset forces the line high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            parity_data <= '0;
            parity_load <= 1'b0;
            tx_out      <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            state       <= state_nxt;
            baud_cnt    <= baud_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            parity_data <= parity_data_nxt;
            parity_load <= parity_load_nxt;
            tx_out      <= tx_out_nxt;
            tx_busy     <= tx_busy_nxt;
            tx_done     <= tx_done_nxt;
        end
    end

    // Next-state sequencing. Output values are derived from the state being entered.
    always_comb begin
        state_nxt       = state;
        baud_cnt_nxt    = baud_cnt;
        bit_idx_nxt     = bit_idx;
        parity_data_nxt = parity_data;
        parity_load_nxt = 1'b0;
        tx_done_nxt     = 1'b0;
        tx_out_nxt      = 1'b1;
        tx_busy_nxt     = 1'b0;

        // In any non-idle state the baud counter runs and wraps at each bit end.
        if (state != IDLE) begin
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                bit_idx_nxt  = '0;
                if (tx_start) begin
                    state_nxt       = START;
                    parity_data_nxt = tx_data;
                    parity_load_nxt = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt   = IDLE;
                    tx_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The parity bit takes parity_in live. That value settles long before the parity state.
        case (state_nxt)
            IDLE:    tx_out_nxt = 1'b1;
            START:   tx_out_nxt = 1'b0;
            DATA:    tx_out_nxt = parity_data_nxt[bit_idx_nxt];
            PARITY:  tx_out_nxt = parity_in ^ PAR_INV;
            STOP:    tx_out_nxt = 1'b1;
            default: tx_out_nxt = 1'b1;
        endcase

        tx_busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl.
// There are three instances, all at 4 clocks per bit: even parity, odd parity
// and no parity. Each instance has its own model of the registered parity
// generator.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       reset;
    logic       tx_start    [3];
    logic [7:0] tx_data     [3];
    logic       parity_load [3];
    logic [7:0] parity_data [3];
    logic       parity_in   [3];
    logic       tx_out      [3];
    logic       tx_busy     [3];
    logic       tx_done     [3];

    int total;
    int bad;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int EN  = (g == 2) ? 0 : 1;
        localparam int ODD = (g == 1) ? 1 : 0;

        uart_tx_ctrl #(
            .CLKS_PER_BIT(4),
            .PARITY_EN   (EN),
            .PARITY_ODD  (ODD)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .tx_start   (tx_start[g]),
            .tx_data    (tx_data[g]),
            .parity_load(parity_load[g]),
            .parity_data(parity_data[g]),
            .parity_in  (parity_in[g]),
            .tx_out     (tx_out[g]),
            .tx_busy    (tx_busy[g]),
            .tx_done    (tx_done[g])
        );

        // External parity generator: registers the XOR of parity_data on parity_load.
        always @(posedge clk or posedge reset) begin
            if (reset) parity_in[g] <= 1'b0;
            else if (parity_load[g]) parity_in[g] <= ^parity_data[g];
        end
    end

    // Called just after a negedge. It raises tx_start in that cycle and checks every cycle of the frame.
    // It returns at the negedge of the tx_done cycle without moving on, so a caller can chain another frame.
    task automatic run_frame(input int d, input logic [7:0] b, input int nbits,
                             input logic [10:0] exp, input int inj_cycle,
                             input logic [7:0] inj_data);
        logic expl;
        tx_data[d]  = b;
        tx_start[d] = 1'b1;
        @(negedge clk);
        tx_start[d] = 1'b0;
        tx_data[d]  = ~b;
        for (int k = 1; k <= nbits * 4; k++) begin
            total++;
            if (tx_out[d] !== exp[(k - 1) / 4])
                begin bad++; $display("[TB] FAIL tx_out dut%0d byte %h cycle %0d: got %b want %b", d, b, k, tx_out[d], exp[(k - 1) / 4]); end
            total++;
            if (tx_busy[d] !== 1'b1)
                begin bad++; $display("[TB] FAIL tx_busy dut%0d byte %h cycle %0d: got %b want 1", d, b, k, tx_busy[d]); end
            total++;
            if (tx_done[d] !== 1'b0)
                begin bad++; $display("[TB] FAIL tx_done_early dut%0d byte %h cycle %0d: got %b want 0", d, b, k, tx_done[d]); end
            expl = (k == 1);
            total++;
            if (parity_load[d] !== expl)
                begin bad++; $display("[TB] FAIL parity_load dut%0d byte %h cycle %0d: got %b want %b", d, b, k, parity_load[d], expl); end
            if (k == inj_cycle) begin
                tx_start[d] = 1'b1;
                tx_data[d]  = inj_data;
            end else begin
                tx_start[d] = 1'b0;
            end
            @(negedge clk);
        end
        tx_start[d] = 1'b0;
        total++;
        if (tx_done[d] !== 1'b1)
            begin bad++; $display("[TB] FAIL tx_done dut%0d byte %h: got %b want 1", d, b, tx_done[d]); end
        total++;
        if (tx_busy[d] !== 1'b0)
            begin bad++; $display("[TB] FAIL busy_end dut%0d byte %h: got %b want 0", d, b, tx_busy[d]); end
        total++;
        if (tx_out[d] !== 1'b1)
            begin bad++; $display("[TB] FAIL idle_line dut%0d byte %h: got %b want 1", d, b, tx_out[d]); end
        total++;
        if (parity_data[d] !== b)
            begin bad++; $display("[TB] FAIL parity_data dut%0d: got %h want %h", d, parity_data[d], b); end
    endtask

    // Waits n cycles. Each cycle it checks that the line is idle high, not busy and tx_done is low.
    task automatic idle_check(input int d, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            total++;
            if (tx_out[d] !== 1'b1 || tx_busy[d] !== 1'b0 || tx_done[d] !== 1'b0)
                begin bad++; $display("[TB] FAIL %s dut%0d cycle %0d: got out=%b busy=%b done=%b want 1 0 0", name, d, k, tx_out[d], tx_busy[d], tx_done[d]); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            tx_start[d] = 1'b0;
            tx_data[d]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (tx_out[d] !== 1'b1 || tx_busy[d] !== 1'b0 || tx_done[d] !== 1'b0 ||
                parity_load[d] !== 1'b0 || parity_data[d] !== 8'h00)
                begin bad++; $display("[TB] FAIL reset_state dut%0d: got out=%b busy=%b done=%b load=%b pdata=%h want 1 0 0 0 00", d, tx_out[d], tx_busy[d], tx_done[d], parity_load[d], parity_data[d]); end
        end
        reset = 1'b0;
        idle_check(0, 2, "post_reset");
    endtask

    // 0xA5 has four ones, so the even-parity bit is 0.
    task automatic test_even_parity();
        run_frame(0, 8'hA5, 11, {1'b1, 1'b0, 8'hA5, 1'b0}, 0, 8'h00);
        idle_check(0, 3, "after_a5");
    endtask

    // Odd parity: 0x01 gives parity bit 0, and 0x00 gives parity bit 1.
    task automatic test_odd_parity();
        run_frame(1, 8'h01, 11, {1'b1, 1'b0, 8'h01, 1'b0}, 0, 8'h00);
        idle_check(1, 2, "after_01");
        run_frame(1, 8'h00, 11, {1'b1, 1'b1, 8'h00, 1'b0}, 0, 8'h00);
        idle_check(1, 2, "after_00");
    endtask

    task automatic test_no_parity();
        run_frame(2, 8'hFF, 10, {1'b0, 1'b1, 8'hFF, 1'b0}, 0, 8'h00);
        idle_check(2, 3, "after_ff");
    endtask

    // A start request in the middle of a frame is dropped, and no second frame follows.
    task automatic test_ignore_busy();
        run_frame(0, 8'h81, 11, {1'b1, 1'b0, 8'h81, 1'b0}, 14, 8'h3C);
        idle_check(0, 6, "no_second_frame");
        total++;
        if (parity_data[0] !== 8'h81)
            begin bad++; $display("[TB] FAIL held_pdata: got %h want 81", parity_data[0]); end
    endtask

    // The second frame is requested in the tx_done cycle. That cycle is the single idle-high gap.
    task automatic test_back_to_back();
        run_frame(0, 8'hA5, 11, {1'b1, 1'b0, 8'hA5, 1'b0}, 0, 8'h00);
        run_frame(0, 8'h55, 11, {1'b1, 1'b0, 8'h55, 1'b0}, 0, 8'h00);
        idle_check(0, 2, "after_b2b");
    endtask

    task automatic test_reset_mid_frame();
        tx_data[0]  = 8'hA5;
        tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
        repeat (17) @(negedge clk);
        total++;
        if (tx_out[0] !== 1'b0 || tx_busy[0] !== 1'b1)
            begin bad++; $display("[TB] FAIL bit3_line: got out=%b busy=%b want 0 1", tx_out[0], tx_busy[0]); end
        #1 reset = 1'b1;
        #1;
        total++;
        if (tx_out[0] !== 1'b1 || tx_busy[0] !== 1'b0)
            begin bad++; $display("[TB] FAIL async_reset: got out=%b busy=%b want 1 0", tx_out[0], tx_busy[0]); end
        @(negedge clk);
        reset = 1'b0;
        idle_check(0, 12, "idle_after_reset");
        run_frame(0, 8'h55, 11, {1'b1, 1'b0, 8'h55, 1'b0}, 0, 8'h00);
        idle_check(0, 2, "after_recover");
    endtask

    // Runs the scenarios in order and prints the summary.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
